td4_prog_mem: RTL

- Program-memory end of the TD4 instruction-fetch interface.
  - Takes the CPU's 4-bit `Adr` (PC).
  - Returns the 4-bit `Instr` opcode and 4-bit `Im` immediate with zero-cycle latency.
- Also contains a bit-serial loader that writes the 16-byte program from an external source.
- While loading, the CPU core is held in reset through `cpu_n_reset`.
- Sits beside the TD4 core at top level: `Adr` → `td4_prog_mem` → `Instr`/`Im`.

---
 rtl/td4_pkg.sv | 14 +
 rtl/td4_prog_mem_shifter.sv | 38 +++
 rtl/td4_prog_mem.sv | 124 ++++++++++++
 3 files changed

// File: rtl/td4_pkg.sv
// Shared types and sizing for the TD4 program memory and its serial loader.
package td4_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    FULL,
    RELEASE
  } prog_state_t;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DEPTH  = 16;

endpackage

// File: rtl/td4_prog_mem_shifter.sv
// MSB-first serial-to-parallel shifter with bit counter; pulses byte_valid on
// the strobe that completes a byte, with the completed byte presented alongside.
module prog_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid
);

  localparam int unsigned           CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'(WIDTH - 1);

  // Only WIDTH-1 bits need storing: the final bit comes straight from bit_in.
  logic [WIDTH-2:0] shift_q;
  logic [CNT_W-1:0] cnt_q;

  assign byte_out   = {shift_q, bit_in};
  assign byte_valid = shift_en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= byte_out[WIDTH-2:0];
      cnt_q   <= byte_valid ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/td4_prog_mem.sv
// TD4 program memory: zero-latency opcode/immediate fetch plus a bit-serial
// loader that holds the CPU in reset while the program is written.
module td4_prog_mem
  import td4_pkg::*;
#(
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned OPC_W  = BYTE_W / 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] Adr,
  output logic [OPC_W-1:0]  Instr,
  output logic [OPC_W-1:0]  Im,
  input  logic              prog_en,
  input  logic              prog_bit,
  input  logic              prog_strobe,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic              cpu_n_reset
);

  localparam int unsigned BW    = 2 * OPC_W;
  localparam int unsigned WORDS = 2 ** ADDR_W;

  prog_state_t       state, state_next;
  logic [BW-1:0]     mem [WORDS];
  logic [BW-1:0]     byte_in;
  logic              byte_valid;
  logic              shift_en;
  logic              clear;
  logic              load_entry;

  assign shift_en   = prog_strobe && (state == LOAD);
  assign load_entry = (state == RUN) && prog_en;

  prog_shifter #(
    .WIDTH(BW)
  ) u_shifter (
    .clk       (clk),
    .n_reset   (n_reset),
    .clear     (clear),
    .shift_en  (shift_en),
    .bit_in    (prog_bit),
    .byte_out  (byte_in),
    .byte_valid(byte_valid)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A completing strobe always writes; a falling prog_en only decides where we go next.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    case (state)
      RUN: begin
        if (prog_en) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          if (!prog_en) begin
            state_next = RELEASE;
          end else if (prog_addr == '1) begin
            state_next = FULL;
          end
        end else if (!prog_en) begin
          state_next = RELEASE;
          clear      = 1'b1;
        end
      end
      FULL: begin
        if (!prog_en) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      prog_addr <= '0;
    end else if (load_entry) begin
      prog_addr <= '0;
    end else if (byte_valid) begin
      prog_addr <= prog_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cpu_n_reset <= 1'b0;
    end else begin
      cpu_n_reset <= (state_next == RUN);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (byte_valid) begin
      mem[prog_addr] <= byte_in;
    end
  end

  assign prog_done    = (state == FULL);
  assign {Instr, Im}  = mem[Adr];

endmodule
